// File: rtl/audio_frame_buffer_pkg.sv
// Shared types and default sizing for the audio frame buffer.
package audio_frame_buffer_pkg;

  localparam int unsigned SAMPLE_W_DEF = 16;
  localparam int unsigned NCH_DEF      = 2;
  localparam int unsigned DEPTH_DEF    = 256;
  localparam int unsigned DROP_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_STALL = 2'd2
  } afb_state_e;

endpackage

// File: rtl/audio_frame_buffer_if.sv
// Codec FIFO, HPS frame handshake and overflow status bundle.
interface audio_frame_buffer_if
  import audio_frame_buffer_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned NCH      = NCH_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF
);
  localparam int unsigned W  = NCH * SAMPLE_W;
  localparam int unsigned AW = $clog2(DEPTH);

  logic              fifo_empty;
  logic [W-1:0]      audio_data;
  logic              fifo_read;
  logic              record_en;
  logic [AW-1:0]     rd_addr;
  logic [W-1:0]      rd_data;
  logic              frame_ack;
  logic              frame_ready;
  logic              ready_bank;
  logic              clr_ovf;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output fifo_empty, audio_data, record_en, rd_addr, frame_ack, clr_ovf,
    input  fifo_read, rd_data, frame_ready, ready_bank, overflow, drop_cnt
  );

  modport slave (
    input  fifo_empty, audio_data, record_en, rd_addr, frame_ack, clr_ovf,
    output fifo_read, rd_data, frame_ready, ready_bank, overflow, drop_cnt
  );

endinterface

// File: rtl/audio_frame_buffer_dpram.sv
// Two-bank sample store: one write port, one registered read port.
module audio_dpram #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  localparam int unsigned NWORDS = 1 << AW;

  logic [W-1:0] mem [NWORDS];
  logic [W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = mem[raddr];
  end

  // Only the output register is reset; array contents are left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_frame_buffer.sv
// Ping-pong capture of codec FIFO words into two frame banks read by the HPS.
module audio_frame_buffer
  import audio_frame_buffer_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned NCH      = NCH_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  audio_frame_buffer_if.slave  bus
);
  localparam int unsigned W  = NCH * SAMPLE_W;
  localparam int unsigned AW = $clog2(DEPTH);

  afb_state_e        state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              frame_ready_q, frame_ready_d;
  logic              ready_bank_q, ready_bank_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic fifo_read_c, wr_en_c, drop_c;
  logic last_word;

  assign last_word = (wr_ptr_q == AW'(DEPTH - 1));

  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.record_en) state_d = ST_FILL;
      ST_FILL: begin
        if (!bus.record_en) state_d = ST_IDLE;
        else if (wr_en_c && last_word && frame_ready_q && !bus.frame_ack)
          state_d = ST_STALL;
      end
      ST_STALL: begin
        if (!bus.record_en)    state_d = ST_IDLE;
        else if (bus.frame_ack) state_d = ST_FILL;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: FIFO pop, RAM write, dropped word
  always_comb begin
    fifo_read_c = 1'b0;
    wr_en_c     = 1'b0;
    drop_c      = 1'b0;
    if (!bus.fifo_empty && (state_q == ST_FILL || state_q == ST_STALL))
      fifo_read_c = 1'b1;
    if (fifo_read_c && state_q == ST_FILL)  wr_en_c = 1'b1;
    if (fifo_read_c && state_q == ST_STALL) drop_c  = 1'b1;
  end

  // Bank ownership, write pointer and overflow bookkeeping
  always_comb begin
    wr_bank_d     = wr_bank_q;
    wr_ptr_d      = wr_ptr_q;
    frame_ready_d = frame_ready_q;
    ready_bank_d  = ready_bank_q;
    overflow_d    = overflow_q;
    drop_cnt_d    = drop_cnt_q;

    if (bus.frame_ack && frame_ready_q) frame_ready_d = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (!bus.record_en) begin
          wr_ptr_d = '0;
        end else if (wr_en_c) begin
          if (!last_word) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end else if (!frame_ready_q || bus.frame_ack) begin
            frame_ready_d = 1'b1;
            ready_bank_d  = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
            wr_ptr_d      = '0;
          end
        end
      end
      ST_STALL: begin
        // wr_bank still points at the completed bank while stalled
        if (!bus.record_en) begin
          wr_ptr_d = '0;
        end else if (bus.frame_ack) begin
          frame_ready_d = 1'b1;
          ready_bank_d  = wr_bank_q;
          wr_bank_d     = ready_bank_q;
          wr_ptr_d      = '0;
        end
      end
      default: ;
    endcase

    if (bus.clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_d + DROP_W'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      frame_ready_q <= 1'b0;
      ready_bank_q  <= 1'b0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_ready_q <= frame_ready_d;
      ready_bank_q  <= ready_bank_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  audio_dpram #(
    .W  (W),
    .AW (AW + 1)
  ) u_dpram (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .we    (wr_en_c),
    .waddr ({wr_bank_q, wr_ptr_q}),
    .wdata (bus.audio_data),
    .raddr ({ready_bank_q, bus.rd_addr}),
    .rdata (bus.rd_data)
  );

  assign bus.fifo_read   = fifo_read_c;
  assign bus.frame_ready = frame_ready_q;
  assign bus.ready_bank  = ready_bank_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Self-checking bench for audio_frame_buffer with DEPTH=4, two 16-bit channels.
module tb_audio_frame_buffer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t     tbl[8];
  logic [31:0] sb_q[$];

  audio_frame_buffer_if #(.SAMPLE_W(16), .NCH(2), .DEPTH(4)) bus ();

  audio_frame_buffer #(.SAMPLE_W(16), .NCH(2), .DEPTH(4)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int k);
    logic [31:0] kv;
    kv = 32'(k);
    return {kv[15:0], kv[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present n words on the FIFO; each must be popped in its own cycle.
  task automatic feed(input int n, input int base, input bit ack_last);
    for (int i = 0; i < n; i++) begin
      bus.fifo_empty = 1'b0;
      bus.audio_data = w(base + i);
      bus.frame_ack  = ack_last && (i == n - 1);
      #1;
      chk("fifo_read_active", 32'(bus.fifo_read), 32'd1);
      @(posedge clk); #1;
    end
    bus.fifo_empty = 1'b1;
    bus.frame_ack  = 1'b0;
  endtask

  task automatic read_word(input logic [1:0] a, input logic [31:0] e);
    bus.rd_addr = a;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (sb_q.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
    else                  chk("rd_data", bus.rd_data, sb_q.pop_front());
  endtask

  task automatic read_bank(input int base);
    for (int i = 0; i < 4; i++) read_word(2'(i), w(base + i));
  endtask

  task automatic pulse_ack();
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
  endtask

  task automatic chk_status(input logic fr, input logic rb, input logic ov, input logic [15:0] dc);
    chk("frame_ready", 32'(fr ? 1 : 0) & 32'd1 ^ 32'(bus.frame_ready) ^ 32'(fr), 32'(fr));
    chk("ready_bank",  32'(bus.ready_bank), 32'(rb));
    chk("overflow",    32'(bus.overflow),   32'(ov));
    chk("drop_cnt",    32'(bus.drop_cnt),   32'(dc));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) begin
      tbl[i].addr     = 2'(i);
      tbl[i].exp      = w(1 + i);
      tbl[4 + i].addr = 2'(3 - i);
      tbl[4 + i].exp  = w(4 - i);
    end

    // Reset: outputs cleared, no pop even with data waiting
    rst_n          = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.audio_data = '0;
    bus.record_en  = 1'b1;
    bus.rd_addr    = '0;
    bus.frame_ack  = 1'b0;
    bus.clr_ovf    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fifo_read", 32'(bus.fifo_read), 32'd0);
    chk("reset_rd_data", bus.rd_data, 32'd0);
    chk_status(1'b0, 1'b0, 1'b0, 16'd0);
    bus.fifo_empty = 1'b1;
    rst_n          = 1'b1;
    @(posedge clk); #1;

    // First frame into bank 0
    feed(4, 1, 1'b0);
    chk_status(1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 8; i++) read_word(tbl[i].addr, tbl[i].exp);

    // Bank 1 fills, then stall drops four words
    feed(8, 5, 1'b0);
    chk_status(1'b1, 1'b0, 1'b1, 16'd4);

    // Ack in STALL hands bank 1 over, capture resumes in bank 0
    pulse_ack();
    chk_status(1'b1, 1'b1, 1'b1, 16'd4);
    read_bank(5);
    feed(4, 13, 1'b1);
    chk_status(1'b1, 1'b0, 1'b1, 16'd4);
    read_bank(13);

    // Ack in FILL releases the bank
    pulse_ack();
    chk("ack_fill_clears", 32'(bus.frame_ready), 32'd0);
    pulse_ack();
    chk("ack_ignored", 32'(bus.frame_ready), 32'd0);

    // Partial frame discarded on record_en low
    bus.record_en = 1'b0;
    @(posedge clk); #1;
    bus.fifo_empty = 1'b0;
    #1;
    chk("idle_no_pop", 32'(bus.fifo_read), 32'd0);
    bus.fifo_empty = 1'b1;
    bus.record_en  = 1'b1;
    @(posedge clk); #1;
    feed(2, 32'h20, 1'b0);
    bus.record_en = 1'b0;
    @(posedge clk); #1;
    bus.fifo_empty = 1'b0;
    #1;
    chk("disable_no_pop", 32'(bus.fifo_read), 32'd0);
    bus.fifo_empty = 1'b1;
    bus.record_en  = 1'b1;
    @(posedge clk); #1;
    feed(4, 32'h30, 1'b0);
    chk_status(1'b1, 1'b1, 1'b1, 16'd4);
    read_bank(32'h30);

    // Overflow clear, then saturate drop_cnt in a long stall
    bus.clr_ovf = 1'b1;
    @(posedge clk); #1;
    bus.clr_ovf = 1'b0;
    chk_status(1'b1, 1'b1, 1'b0, 16'd0);
    feed(4, 32'h40, 1'b0);
    chk_status(1'b1, 1'b1, 1'b0, 16'd0);
    bus.fifo_empty = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("drop_cnt_fffe", 32'(bus.drop_cnt), 32'h0000_FFFE);
    repeat (3) @(posedge clk);
    #1;
    chk_status(1'b1, 1'b1, 1'b1, 16'hFFFF);
    bus.clr_ovf = 1'b1;
    @(posedge clk); #1;
    bus.clr_ovf    = 1'b0;
    bus.fifo_empty = 1'b1;
    chk_status(1'b1, 1'b1, 1'b1, 16'd1);
    bus.clr_ovf = 1'b1;
    @(posedge clk); #1;
    bus.clr_ovf = 1'b0;
    chk_status(1'b1, 1'b1, 1'b0, 16'd0);

    // Leave STALL, start a frame in bank 1, then reset asynchronously
    pulse_ack();
    chk_status(1'b1, 1'b0, 1'b0, 16'd0);
    read_bank(32'h40);
    feed(2, 32'h60, 1'b0);
    #3;
    rst_n          = 1'b0;
    bus.fifo_empty = 1'b0;
    #1;
    chk("async_fifo_read", 32'(bus.fifo_read), 32'd0);
    chk("async_rd_data", bus.rd_data, 32'd0);
    chk_status(1'b0, 1'b0, 1'b0, 16'd0);
    @(posedge clk); #3;
    bus.fifo_empty = 1'b1;
    rst_n          = 1'b1;
    @(posedge clk); #1;
    feed(4, 32'h50, 1'b0);
    chk_status(1'b1, 1'b0, 1'b0, 16'd0);
    read_bank(32'h50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
